// File: rtl/wb_write_arbiter.sv
// Writeback arbiter: merges ALU (A) and load-unit (B) writes into one register file
// write port, with an anti-starvation priority swap for B and in-flight write forwarding.
module wb_write_arbiter #(
    parameter int unsigned ADDR_WIDTH   = 5,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned STARVE_LIMIT = 4,
    parameter bit          ZERO_DISCARD = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_data,
    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_data,
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    input  logic [ADDR_WIDTH-1:0] q_addr,
    output logic                  q_hit,
    output logic [DATA_WIDTH-1:0] q_data
);

    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic {
        PRIO_A,
        PRIO_B
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [CNT_W-1:0]        starve_cnt;
    logic [CNT_W-1:0]        starve_cnt_nxt;
    logic                    xfer;
    logic                    wen_nxt;
    logic [ADDR_WIDTH-1:0]   win_addr;
    logic [DATA_WIDTH-1:0]   win_data;

    // Grant and priority-swap logic; no grants while reset is asserted.
    always_comb begin
        a_ready        = 1'b0;
        b_ready        = 1'b0;
        state_nxt      = state;
        starve_cnt_nxt = starve_cnt;
        if (!rst) begin
            case (state)
                PRIO_A: begin
                    a_ready = a_valid;
                    b_ready = b_valid & ~a_valid;
                    if (b_ready || !b_valid) begin
                        starve_cnt_nxt = '0;
                    end else if (a_ready) begin
                        if (starve_cnt < CNT_W'(STARVE_LIMIT)) begin
                            starve_cnt_nxt = starve_cnt + CNT_W'(1);
                        end
                        if (starve_cnt == CNT_W'(STARVE_LIMIT - 1)) begin
                            state_nxt = PRIO_B;
                        end
                    end
                end
                PRIO_B: begin
                    b_ready = b_valid;
                    a_ready = a_valid & ~b_valid;
                    if (b_ready || !b_valid) begin
                        state_nxt      = PRIO_A;
                        starve_cnt_nxt = '0;
                    end
                end
                default: begin
                    state_nxt      = PRIO_A;
                    starve_cnt_nxt = '0;
                end
            endcase
        end
    end

    assign xfer     = a_ready | b_ready;
    assign win_addr = a_ready ? a_addr : b_addr;
    assign win_data = a_ready ? a_data : b_data;
    assign wen_nxt  = xfer & ~(ZERO_DISCARD && (win_addr == '0));

    // State, counter and the single output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= PRIO_A;
            starve_cnt <= '0;
            rf_wen     <= 1'b0;
            rf_waddr   <= '0;
            rf_wdata   <= '0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_cnt_nxt;
            rf_wen     <= wen_nxt;
            if (xfer) begin
                rf_waddr <= win_addr;
                rf_wdata <= win_data;
            end
        end
    end

    assign q_hit  = rf_wen & (rf_waddr == q_addr);
    assign q_data = rf_wdata;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Scoreboard bench for wb_write_arbiter: a grant model pushes expected writes,
// a negedge monitor pops and compares rf_* and forwarding outputs.
module tb_wb_write_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid, b_valid;
    logic [4:0]  a_addr, b_addr, q_addr;
    logic [31:0] a_data, b_data;
    logic        a_ready, b_ready, rf_wen, q_hit;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata, q_data;
    logic        a_ready2, b_ready2, rf_wen2, q_hit2;
    logic [4:0]  rf_waddr2;
    logic [31:0] rf_wdata2, q_data2;

    typedef struct {
        int          due;
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t  exp_q[$];
    wr_t  exp_q2[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    logic mon_on = 1'b0;
    logic done = 1'b0;
    logic exp_a_rdy = 1'b0;
    logic exp_b_rdy = 1'b0;
    logic m_prio_b = 1'b0;
    int   m_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    wb_write_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .q_addr(q_addr), .q_hit(q_hit), .q_data(q_data)
    );

    wb_write_arbiter #(.STARVE_LIMIT(LIMIT), .ZERO_DISCARD(1'b0)) dut_nz (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready2), .a_addr(a_addr), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready2), .b_addr(b_addr), .b_data(b_data),
        .rf_wen(rf_wen2), .rf_waddr(rf_waddr2), .rf_wdata(rf_wdata2),
        .q_addr(q_addr), .q_hit(q_hit2), .q_data(q_data2)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s cyc=%0d: got %0h want %0h", nm, cyc, act, req);
        end
    endtask

    // Monitor: the only process that steps the counters.
    always @(negedge clk) begin
        if (mon_on) begin
            logic due1, due2, eh;
            chk("a_ready", 32'(a_ready), 32'(exp_a_rdy));
            chk("b_ready", 32'(b_ready), 32'(exp_b_rdy));
            chk("a_ready_nz", 32'(a_ready2), 32'(exp_a_rdy));
            chk("b_ready_nz", 32'(b_ready2), 32'(exp_b_rdy));

            while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
                chk("rf_missing_write", 32'(exp_q[0].due), 32'(cyc));
                void'(exp_q.pop_front());
            end
            due1 = (exp_q.size() > 0) && (exp_q[0].due == cyc);
            chk("rf_wen", 32'(rf_wen), 32'(due1));
            eh = due1 && (exp_q[0].addr == q_addr);
            chk("q_hit", 32'(q_hit), 32'(eh));
            if (due1) begin
                if (rf_wen) begin
                    chk("rf_waddr", 32'(rf_waddr), 32'(exp_q[0].addr));
                    chk("rf_wdata", rf_wdata, exp_q[0].data);
                end
                if (eh && q_hit) chk("q_data", q_data, exp_q[0].data);
                void'(exp_q.pop_front());
            end

            while (exp_q2.size() > 0 && exp_q2[0].due < cyc) begin
                chk("rf_missing_write_nz", 32'(exp_q2[0].due), 32'(cyc));
                void'(exp_q2.pop_front());
            end
            due2 = (exp_q2.size() > 0) && (exp_q2[0].due == cyc);
            chk("rf_wen_nz", 32'(rf_wen2), 32'(due2));
            if (due2) begin
                if (rf_wen2) begin
                    chk("rf_waddr_nz", 32'(rf_waddr2), 32'(exp_q2[0].addr));
                    chk("rf_wdata_nz", rf_wdata2, exp_q2[0].data);
                end
                void'(exp_q2.pop_front());
            end

            if (done) begin
                chk("queue_left", 32'(exp_q.size()), 32'd0);
                chk("queue_left_nz", 32'(exp_q2.size()), 32'd0);
                $display("test done: total=%0d bad=%0d", total, bad);
                $finish;
            end
        end
    end

    // Drive one cycle of stimulus, predict grants, push expected writes, advance the model.
    task automatic step(input logic r, input logic av, input logic [4:0] aa, input logic [31:0] ad,
                        input logic bv, input logic [4:0] ba, input logic [31:0] bd,
                        input logic [4:0] qa);
        logic ea, eb;
        wr_t  w;
        @(posedge clk);
        #1;
        rst = r; a_valid = av; a_addr = aa; a_data = ad;
        b_valid = bv; b_addr = ba; b_data = bd; q_addr = qa;
        if (r) begin
            ea = 1'b0; eb = 1'b0;
        end else if (!m_prio_b) begin
            ea = av; eb = bv && !av;
        end else begin
            eb = bv; ea = av && !bv;
        end
        exp_a_rdy = ea;
        exp_b_rdy = eb;
        if (ea || eb) begin
            w.due  = cyc + 1;
            w.addr = ea ? aa : ba;
            w.data = ea ? ad : bd;
            exp_q2.push_back(w);
            if (w.addr != 5'd0) exp_q.push_back(w);
        end
        if (r) begin
            m_prio_b = 1'b0; m_cnt = 0;
        end else if (!m_prio_b) begin
            if (eb || !bv) m_cnt = 0;
            else if (ea) begin
                if (m_cnt == LIMIT - 1) m_prio_b = 1'b1;
                if (m_cnt < LIMIT) m_cnt++;
            end
        end else if (eb || !bv) begin
            m_prio_b = 1'b0; m_cnt = 0;
        end
        mon_on = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        av, bv;
        logic [4:0]  aa, ba;
        logic [31:0] ad, bd;
        rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0;
        a_addr = '0; b_addr = '0; a_data = '0; b_data = '0; q_addr = '0;

        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 5'd2, 32'h1111, 1, 5'd4, 32'h2222, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);

        // single A write
        step(0, 1, 5'd3, 32'hDEAD_BEEF, 0, 0, 0, 5'd3);
        step(0, 0, 0, 0, 0, 0, 0, 5'd3);
        step(0, 0, 0, 0, 0, 0, 0, 5'd3);

        // conflict: A wins 4 cycles, B once, then A
        for (int i = 0; i < 4; i++)
            step(0, 1, 5'(10 + i), 32'(32'hA000 + i), 1, 5'd20, 32'h0B0B, 5'd20);
        step(0, 1, 5'd14, 32'hA004, 1, 5'd20, 32'h0B0B, 5'd14);
        step(0, 1, 5'd14, 32'hA004, 0, 0, 0, 5'd14);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);

        // zero discard
        step(0, 0, 0, 0, 1, 5'd0, 32'd5, 5'd0);
        step(0, 0, 0, 0, 0, 0, 0, 5'd0);
        step(0, 0, 0, 0, 0, 0, 0, 5'd0);

        // forwarding
        step(0, 1, 5'd7, 32'h55, 0, 0, 0, 5'd0);
        step(0, 1, 5'd7, 32'h66, 0, 0, 0, 5'd7);
        step(0, 0, 0, 0, 0, 0, 0, 5'd6);
        step(0, 0, 0, 0, 0, 0, 0, 5'd7);

        // reset while in PRIO_B with B pending
        for (int i = 0; i < 4; i++)
            step(0, 1, 5'(1 + i), 32'(32'hC000 + i), 1, 5'd9, 32'h0999, 5'd4);
        step(1, 1, 5'd5, 32'hC004, 1, 5'd9, 32'h0999, 5'd4);
        step(0, 1, 5'd5, 32'hC004, 1, 5'd9, 32'h0999, 5'd5);
        step(0, 0, 0, 0, 1, 5'd9, 32'h0999, 5'd9);
        step(0, 0, 0, 0, 0, 0, 0, 5'd9);

        // same index from A then B on consecutive cycles
        step(0, 1, 5'd12, 32'h1234, 0, 0, 0, 5'd12);
        step(0, 0, 0, 0, 1, 5'd12, 32'h5678, 5'd12);
        step(0, 0, 0, 0, 0, 0, 0, 5'd12);
        step(0, 0, 0, 0, 0, 0, 0, 5'd12);

        // randomised traffic with source hold
        av = 1'b0; bv = 1'b0; aa = '0; ba = '0; ad = '0; bd = '0;
        for (int i = 0; i < 400; i++) begin
            if (!(av && !exp_a_rdy)) begin
                av = ($urandom_range(0, 3) != 0);
                aa = 5'($urandom_range(0, 31));
                ad = $urandom;
            end
            if (!(bv && !exp_b_rdy)) begin
                bv = ($urandom_range(0, 2) != 0);
                ba = 5'($urandom_range(0, 31));
                bd = $urandom;
            end
            step(0, av, aa, ad, bv, ba, bd, 5'($urandom_range(0, 31)));
        end

        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        done = 1'b1;
    end

endmodule
